// File: rtl/fb_write_scheduler.sv
// fb_write_scheduler
//   Sole owner of the frame-buffer write port and of buffer_select. Merges
//   single host writes (via a one-entry hold register) with a constant-colour
//   fill engine, at most one write per cycle. Front/back swaps are sequenced
//   so that the toggle only lands once the fill is idle and no host write is
//   pending.
//
// Ports
//   clk, rst            clk100 and asynchronous active-high reset
//   host_wr/addr/data   host write strobe and payload
//   host_busy           hold register occupied
//   host_drop           pulse: host write lost to a full hold register
//   fill_start/base/len/color  fill request and its parameters
//   fill_busy/fill_done fill engine active / completion pulse
//   swap_req            buffer swap request
//   swap_busy/swap_done swap sequence active / completion pulse
//   buffer_current      displayed buffer (already in clk domain)
//   buffer_select       requested display buffer
//   wr/wr_addr/wr_data  registered frame-buffer write port
module fb_write_scheduler #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 12,
  parameter int unsigned LEN_W  = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_wr,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_busy,
  output logic              host_drop,
  input  logic              fill_start,
  input  logic [ADDR_W-1:0] fill_base,
  input  logic [LEN_W-1:0]  fill_len,
  input  logic [DATA_W-1:0] fill_color,
  output logic              fill_busy,
  output logic              fill_done,
  input  logic              swap_req,
  output logic              swap_busy,
  output logic              swap_done,
  input  logic              buffer_current,
  output logic              buffer_select,
  output logic              wr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  typedef enum logic [1:0] {FILL_IDLE, FILL_RUN, FILL_DONE} fill_state_e;
  typedef enum logic [1:0] {SWAP_IDLE, SWAP_DRAIN, SWAP_TOGGLE, SWAP_WAIT} swap_state_e;

  fill_state_e       fill_state_q, fill_state_d;
  swap_state_e       swap_state_q, swap_state_d;

  logic              hold_valid_q, hold_valid_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic              host_drop_q, host_drop_d;

  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [DATA_W-1:0] color_q, color_d;
  logic              fill_done_q, fill_done_d;

  logic              buffer_select_q, buffer_select_d;
  logic              swap_done_q, swap_done_d;

  logic              prio_host_q, prio_host_d;

  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;

  logic              req_host, req_fill;
  logic              grant_host, grant_fill;

  // Arbitration: on contention the side not served last wins. Any cycle
  // without a host grant hands priority back to the host, so after idle or a
  // fill-only stretch the host goes first.
  always_comb begin
    req_host    = hold_valid_q;
    req_fill    = (fill_state_q == FILL_RUN);
    grant_host  = req_host && (!req_fill || prio_host_q);
    grant_fill  = req_fill && !grant_host;
    prio_host_d = !grant_host;

    wr_d      = grant_host || grant_fill;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (grant_host) begin
      wr_addr_d = hold_addr_q;
      wr_data_d = hold_data_q;
    end else if (grant_fill) begin
      wr_addr_d = cur_addr_q;
      wr_data_d = color_q;
    end
  end

  // Host hold register; a write arriving while the held entry is being
  // granted refills the register in the same cycle.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    host_drop_d  = host_wr && hold_valid_q && !grant_host;
    if (host_wr && (!hold_valid_q || grant_host)) begin
      hold_valid_d = 1'b1;
      hold_addr_d  = host_addr;
      hold_data_d  = host_data;
    end else if (grant_host) begin
      hold_valid_d = 1'b0;
    end
  end

  // Fill engine
  always_comb begin
    fill_state_d = fill_state_q;
    cur_addr_d   = cur_addr_q;
    remaining_d  = remaining_q;
    color_d      = color_q;
    fill_done_d  = (fill_state_q == FILL_DONE);
    case (fill_state_q)
      FILL_IDLE: begin
        if (fill_start && (swap_state_q != SWAP_DRAIN)) begin
          if (fill_len == '0) begin
            fill_state_d = FILL_DONE;
          end else begin
            cur_addr_d   = fill_base;
            remaining_d  = fill_len;
            color_d      = fill_color;
            fill_state_d = FILL_RUN;
          end
        end
      end
      FILL_RUN: begin
        if (grant_fill) begin
          cur_addr_d  = cur_addr_q + ADDR_W'(1);
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            fill_state_d = FILL_DONE;
          end
        end
      end
      FILL_DONE: fill_state_d = FILL_IDLE;
      default:   fill_state_d = FILL_IDLE;
    endcase
  end

  // Swap sequencer
  always_comb begin
    swap_state_d    = swap_state_q;
    buffer_select_d = buffer_select_q;
    swap_done_d     = 1'b0;
    case (swap_state_q)
      SWAP_IDLE: begin
        if (swap_req) swap_state_d = SWAP_DRAIN;
      end
      SWAP_DRAIN: begin
        if (!hold_valid_q && (fill_state_q == FILL_IDLE)) swap_state_d = SWAP_TOGGLE;
      end
      SWAP_TOGGLE: begin
        buffer_select_d = ~buffer_select_q;
        swap_state_d    = SWAP_WAIT;
      end
      SWAP_WAIT: begin
        if (buffer_current == buffer_select_q) begin
          swap_done_d  = 1'b1;
          swap_state_d = SWAP_IDLE;
        end
      end
      default: swap_state_d = SWAP_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_state_q    <= FILL_IDLE;
      swap_state_q    <= SWAP_IDLE;
      hold_valid_q    <= 1'b0;
      hold_addr_q     <= '0;
      hold_data_q     <= '0;
      host_drop_q     <= 1'b0;
      cur_addr_q      <= '0;
      remaining_q     <= '0;
      color_q         <= '0;
      fill_done_q     <= 1'b0;
      buffer_select_q <= 1'b0;
      swap_done_q     <= 1'b0;
      prio_host_q     <= 1'b1;
      wr_q            <= 1'b0;
      wr_addr_q       <= '0;
      wr_data_q       <= '0;
    end else begin
      fill_state_q    <= fill_state_d;
      swap_state_q    <= swap_state_d;
      hold_valid_q    <= hold_valid_d;
      hold_addr_q     <= hold_addr_d;
      hold_data_q     <= hold_data_d;
      host_drop_q     <= host_drop_d;
      cur_addr_q      <= cur_addr_d;
      remaining_q     <= remaining_d;
      color_q         <= color_d;
      fill_done_q     <= fill_done_d;
      buffer_select_q <= buffer_select_d;
      swap_done_q     <= swap_done_d;
      prio_host_q     <= prio_host_d;
      wr_q            <= wr_d;
      wr_addr_q       <= wr_addr_d;
      wr_data_q       <= wr_data_d;
    end
  end

  assign host_busy     = hold_valid_q;
  assign host_drop     = host_drop_q;
  assign fill_busy     = (fill_state_q != FILL_IDLE);
  assign fill_done     = fill_done_q;
  assign swap_busy     = (swap_state_q != SWAP_IDLE);
  assign swap_done     = swap_done_q;
  assign buffer_select = buffer_select_q;
  assign wr            = wr_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;

endmodule

// File: tb/tb_fb_write_scheduler.sv
// tb_fb_write_scheduler
//   Directed bench for fb_write_scheduler. A transaction-level model (hold
//   register, a queue of pending fill writes, swap phase) predicts every
//   output each cycle; literal expectations pin the scenarios.
module tb_fb_write_scheduler;

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 12;
  localparam int unsigned LW = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          host_wr = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_data = '0;
  logic          host_busy, host_drop;
  logic          fill_start = 1'b0;
  logic [AW-1:0] fill_base = '0;
  logic [LW-1:0] fill_len = '0;
  logic [DW-1:0] fill_color = '0;
  logic          fill_busy, fill_done;
  logic          swap_req = 1'b0;
  logic          swap_busy, swap_done;
  logic          buffer_current;
  logic          buffer_select;
  logic          wr;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  fb_write_scheduler #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst),
    .host_wr(host_wr), .host_addr(host_addr), .host_data(host_data),
    .host_busy(host_busy), .host_drop(host_drop),
    .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len),
    .fill_color(fill_color), .fill_busy(fill_busy), .fill_done(fill_done),
    .swap_req(swap_req), .swap_busy(swap_busy), .swap_done(swap_done),
    .buffer_current(buffer_current), .buffer_select(buffer_select),
    .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  // Display side: buffer_current follows buffer_select after 5 clocks.
  logic [4:0] bc_pipe = '0;
  always @(posedge clk) bc_pipe <= {bc_pipe[3:0], buffer_select};
  assign buffer_current = bc_pipe[4];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  bit            m_hold = 0;
  logic [AW-1:0] m_haddr = '0;
  logic [DW-1:0] m_hdata = '0;
  logic [AW-1:0] fq_a[$];
  logic [DW-1:0] fq_d[$];
  bit            m_fill_tail = 0;   // last fill word written, completion pending
  bit            m_host_turn = 1;
  int            m_swap = 0;        // 0 idle, 1 drain, 2 toggle, 3 wait
  bit            m_sel = 0;

  bit            exp_wr = 0, exp_drop = 0, exp_hbusy = 0, exp_fbusy = 0;
  bit            exp_fdone = 0, exp_sbusy = 0, exp_sdone = 0, exp_sel = 0;
  logic [AW-1:0] exp_addr = '0;
  logic [DW-1:0] exp_data = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hold = 0; fq_a.delete(); fq_d.delete(); m_fill_tail = 0;
      m_host_turn = 1; m_swap = 0; m_sel = 0;
      exp_wr = 0; exp_drop = 0; exp_hbusy = 0; exp_fbusy = 0;
      exp_fdone = 0; exp_sbusy = 0; exp_sdone = 0; exp_sel = 0;
    end else begin
      bit hreq, freq, gh, gf, fill_idle, tail_next;
      hreq = m_hold;
      freq = (fq_a.size() != 0);
      fill_idle = !freq && !m_fill_tail;
      gh = hreq && (!freq || m_host_turn);
      gf = freq && !gh;
      exp_wr = gh || gf;
      tail_next = 0;
      if (gh) begin
        exp_addr = m_haddr; exp_data = m_hdata;
      end else if (gf) begin
        exp_addr = fq_a.pop_front(); exp_data = fq_d.pop_front();
        tail_next = (fq_a.size() == 0);
      end
      m_host_turn = !gh;
      exp_drop = host_wr && m_hold && !gh;
      if (host_wr && (!m_hold || gh)) begin
        m_hold = 1; m_haddr = host_addr; m_hdata = host_data;
      end else if (gh) m_hold = 0;
      exp_fdone = m_fill_tail;
      if (fill_idle && fill_start && m_swap != 1) begin
        if (fill_len == 0) tail_next = 1;
        else for (int unsigned i = 0; i < fill_len; i++) begin
          fq_a.push_back(AW'(fill_base + i));
          fq_d.push_back(fill_color);
        end
      end
      m_fill_tail = tail_next;
      exp_sdone = 0;
      case (m_swap)
        0: if (swap_req) m_swap = 1;
        1: if (!hreq && fill_idle) m_swap = 2;
        2: begin m_sel = !m_sel; m_swap = 3; end
        default: if (buffer_current == m_sel) begin m_swap = 0; exp_sdone = 1; end
      endcase
      exp_hbusy = m_hold;
      exp_fbusy = (fq_a.size() != 0) || m_fill_tail;
      exp_sbusy = (m_swap != 0);
      exp_sel = m_sel;
    end
  end

  always @(negedge clk) begin
    check("wr", wr, exp_wr);
    if (exp_wr) begin
      check("wr_addr", wr_addr, exp_addr);
      check("wr_data", wr_data, exp_data);
    end
    check("host_busy", host_busy, exp_hbusy);
    check("host_drop", host_drop, exp_drop);
    check("fill_busy", fill_busy, exp_fbusy);
    check("fill_done", fill_done, exp_fdone);
    check("swap_busy", swap_busy, exp_sbusy);
    check("swap_done", swap_done, exp_sdone);
    check("buffer_select", buffer_select, exp_sel);
  end

  // ---------------- event log ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            w_cyc[$];
  logic [AW-1:0] w_addr[$];
  logic [DW-1:0] w_data[$];
  int            fd_cyc[$];
  int            sd_cyc[$];
  int            drops = 0;
  int            bc_cyc = -1;
  int            sel_cyc = -1;
  logic          prev_sel = 1'b0;

  always @(posedge clk) begin
    #1;
    if (wr) begin w_cyc.push_back(cyc); w_addr.push_back(wr_addr); w_data.push_back(wr_data); end
    if (fill_done) fd_cyc.push_back(cyc);
    if (swap_done) sd_cyc.push_back(cyc);
    if (host_drop) drops++;
    if (buffer_current && bc_cyc < 0) bc_cyc = cyc;
    if (buffer_select != prev_sel && sel_cyc < 0) sel_cyc = cyc;
    prev_sel = buffer_select;
  end

  task automatic clear_log();
    w_cyc.delete(); w_addr.delete(); w_data.delete();
    fd_cyc.delete(); sd_cyc.delete();
    drops = 0; bc_cyc = -1; sel_cyc = -1;
  endtask

  task automatic start_fill(input logic [AW-1:0] b, input logic [LW-1:0] l, input logic [DW-1:0] c);
    fill_start = 1'b1; fill_base = b; fill_len = l; fill_color = c;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit ok;
    int c0, n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_wr", wr, 0);
    check("reset_sel", buffer_select, 0);
    repeat (2) @(negedge clk);

    // Single host write: wr two cycles after the strobe.
    host_wr = 1'b1; host_addr = 14'h0005; host_data = 12'hF0F;
    @(negedge clk); host_wr = 1'b0;
    check("host_busy_hold", host_busy, 1);
    check("host_wr_early", wr, 0);
    @(negedge clk);
    check("host_wr_strobe", wr, 1);
    check("host_wr_addr", wr_addr, 14'h0005);
    check("host_wr_data", wr_data, 12'hF0F);
    check("host_busy_clear", host_busy, 0);
    repeat (3) @(negedge clk);

    // Fill across the address wrap.
    clear_log();
    start_fill(14'h3FFE, 15'd4, 12'h00F);
    @(negedge clk); fill_start = 1'b0;
    repeat (10) @(negedge clk);
    check("wrap_count", w_cyc.size(), 4);
    if (w_cyc.size() == 4) begin
      check("wrap_a0", w_addr[0], 14'h3FFE);
      check("wrap_a1", w_addr[1], 14'h3FFF);
      check("wrap_a2", w_addr[2], 14'h0000);
      check("wrap_a3", w_addr[3], 14'h0001);
      check("wrap_data", w_data[3], 12'h00F);
      check("wrap_consecutive", w_cyc[3] - w_cyc[0], 3);
      check("wrap_done_count", fd_cyc.size(), 1);
      if (fd_cyc.size() == 1) check("wrap_done_time", fd_cyc[0], w_cyc[3] + 1);
    end

    // Fill of 8 interleaved with a host write every other cycle.
    clear_log();
    for (int i = 0; i < 8; i++) begin
      host_wr = 1'b1; host_addr = AW'(14'h1000 + i); host_data = DW'(i);
      if (i == 0) start_fill(14'h0200, 15'd8, 12'hABC);
      @(negedge clk);
      host_wr = 1'b0; fill_start = 1'b0;
      @(negedge clk);
    end
    repeat (8) @(negedge clk);
    check("alt_count", w_cyc.size(), 16);
    check("alt_drops", drops, 0);
    if (w_cyc.size() == 16) begin
      ok = 1;
      for (int k = 0; k < 16; k++) begin
        if (w_cyc[k] != w_cyc[0] + k) ok = 0;
        if (k % 2 == 0 && w_addr[k] != AW'(14'h1000 + k / 2)) ok = 0;
        if (k % 2 == 1 && (w_addr[k] != AW'(14'h0200 + k / 2) || w_data[k] != 12'hABC)) ok = 0;
      end
      check("alt_order", ok, 1);
    end

    // Host strobes on three consecutive cycles during a fill: one is lost.
    clear_log();
    start_fill(14'h0300, 15'd6, 12'h555);
    @(negedge clk); fill_start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      host_wr = 1'b1; host_addr = AW'(14'h2000 + i); host_data = 12'h0AA;
      @(negedge clk);
    end
    host_wr = 1'b0;
    repeat (10) @(negedge clk);
    check("drop_count", drops, 1);
    n = 0;
    foreach (w_addr[k]) if (w_addr[k][13]) n++;
    check("drop_host_writes", n, 2);
    check("drop_total_writes", w_cyc.size(), 8);

    // Swap requested together with a 16-word fill.
    clear_log();
    start_fill(14'h0400, 15'd16, 12'h123);
    swap_req = 1'b1;
    @(negedge clk); fill_start = 1'b0; swap_req = 1'b0;
    n = 0;
    while (!fill_done && n < 100) begin @(negedge clk); n++; end
    check("swap_fill_done_seen", fill_done, 1);
    check("swap_drain_busy", swap_busy, 1);
    start_fill(14'h0800, 15'd3, 12'hFFF);  // lands while draining
    @(negedge clk); fill_start = 1'b0;
    n = 0;
    while (!swap_done && n < 100) begin @(negedge clk); n++; end
    check("swap_done_seen", swap_done, 1);
    repeat (4) @(negedge clk);
    check("swap_fill_writes", w_cyc.size(), 16);
    check("swap_fill_done_count", fd_cyc.size(), 1);
    check("swap_sel_after_fill", (sel_cyc > w_cyc[w_cyc.size()-1]) ? 1 : 0, 1);
    check("swap_done_count", sd_cyc.size(), 1);
    if (sd_cyc.size() == 1) check("swap_done_time", sd_cyc[0], bc_cyc + 1);
    check("swap_sel_final", buffer_select, 1);

    // Zero-length fill.
    clear_log();
    c0 = cyc;
    start_fill(14'h0123, 15'd0, 12'h321);
    @(negedge clk); fill_start = 1'b0;
    repeat (5) @(negedge clk);
    check("zero_len_writes", w_cyc.size(), 0);
    check("zero_len_done_count", fd_cyc.size(), 1);
    if (fd_cyc.size() == 1) check("zero_len_done_time", fd_cyc[0], c0 + 2);

    // Reset in the middle of a long fill.
    clear_log();
    start_fill(14'h0100, 15'd1024, 12'h777);
    @(negedge clk); fill_start = 1'b0;
    n = 0;
    while (w_cyc.size() < 10 && n < 100) begin @(negedge clk); n++; end
    check("rst_mid_progress", (w_cyc.size() >= 10) ? 1 : 0, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_wr", wr, 0);
    check("rst_async_fill_busy", fill_busy, 0);
    check("rst_async_sel", buffer_select, 0);
    check("rst_async_wr_addr", wr_addr, 0);
    check("rst_async_wr_data", wr_data, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("rst_no_fill_done", fd_cyc.size(), 0);
    check("rst_fill_idle", fill_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule
